ofdm_tx_frame_sequencer: RTL and testbench
==========================================

# ofdm_tx_frame_sequencer

Sequences one OFDM transmit frame from the IFFT sample buffer into the DUC chain's S_AXIS input, with cyclic-prefix insertion per symbol. Also latches the DUC carrier word and interpolation ratio at frame start. Sits between the TX sample memory and `DAC_Chain`. It replaces the hand-driven `s_tdata`/`s_tlast` stimulus with a hardware controller.

## Interface
- `ADDR_W`, 16: sample-memory address width.
- `SYM_W`, 8: width of the symbol-count field.
- `GAP_W`, 16: width of the inter-frame gap counter.
- `FC_RST`, 32'd10737418: reset value of `dac_fc_scaled`.
- `INTERP_RST`, 16'd40: reset value of `interp_ratio`.
- `aclk` in 1: system clock (100 MHz domain).
- `areset` in 1: asynchronous, active-high reset.
- `start` in 1: frame request pulse, honoured only in IDLE.
- `abort` in 1: terminate the current frame.
- `cfg_nfft_log2` in 4: FFT size as log2; legal range 6..12.
- `cfg_cp_len` in 13: cyclic-prefix length; must be < nfft.
- `cfg_num_syms` in SYM_W: symbols per frame; must be ≥ 1.
- `cfg_gap` in GAP_W: idle cycles held after the last beat before `done`.
- `cfg_dac_fc` in 32: DUC carrier word.
- `cfg_interp` in 16: interpolation ratio.
- `mem_ren` out 1, `mem_raddr` out ADDR_W: sample-memory read port.
- `mem_rdata` in 32: read data, returned exactly 1 cycle after `mem_ren`. Format is {Q[31:16], I[15:0]}.
- `m_axis_tdata` out 32, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1, `m_axis_tkeep` out 4: stream to the DUC.
- `dac_fc_scaled` out 32, `interp_ratio` out 16: held configuration.
- `busy` out 1, `done` out 1 (pulse), `aborted` out 1 (pulse), `err_cfg` out 1 (pulse).

## Operation
- States: IDLE, CP, BODY, GAP.
- **IDLE, start accepted:**
  - Check config. If invalid, pulse `err_cfg` for 1 cycle and stay in IDLE.
  - If valid, latch all `cfg_*` into shadow registers, update `dac_fc_scaled`/`interp_ratio`, set symbol index s=0, and go to CP.
- **Addressing:** N = 1<<nfft_log2. Symbol s occupies addresses s·N .. s·N+N−1. Address arithmetic is a shift-add of width ADDR_W; wrap is not checked.
- **CP:** issue reads at s·N + N − cp_len .. s·N + N − 1. If cp_len = 0, skip CP and go straight to BODY.
- **BODY:** issue reads at s·N .. s·N + N − 1. At the end of the body:
  - if s < num_syms − 1: s++, go to CP;
  - otherwise go to GAP once the last beat has been accepted downstream.
- **GAP:** count cfg_gap cycles. On expiry, pulse `done` and go to IDLE. If cfg_gap = 0, pulse `done` on the cycle after the last beat is accepted.
- **Output buffer:** a 2-entry FIFO. A read is issued only when occupancy plus in-flight reads is < 2, so no beat is ever lost under backpressure.
- **`m_axis_tlast`:** high only on the final BODY beat of the final symbol.
- **`m_axis_tkeep`:** constant 4'b1111.
- **Abort (CP/BODY/GAP):**
  - The next cycle: flush the FIFO, discard the in-flight read, deassert `tvalid`, pulse `aborted`, go to IDLE.
  - `tlast` is never emitted for an aborted frame. `done` is not pulsed.
- **Event priorities:**
  - `abort` and `start` together in IDLE: abort wins, start is ignored, no pulse.
  - `start` while busy: ignored.
- **Configuration stability:** `cfg_*` changes during a frame have no effect. `dac_fc_scaled`/`interp_ratio` change only on an accepted start.
- **`busy`:** high in CP, BODY and GAP.

## Timing
- **Reset values:** state IDLE, all pulses 0, `tvalid`=0, `tlast`=0, `mem_ren`=0, `dac_fc_scaled`=FC_RST, `interp_ratio`=INTERP_RST, FIFO empty.
- `start` is sampled at edge T. At T+1: `busy`=1 and the first `mem_ren` is issued. At T+2: data is written to the FIFO and `m_axis_tvalid`=1.
- With `tready` held high, throughput is 1 beat/cycle, including across CP→BODY and symbol boundaries (no bubbles).
- A frame is num_syms·(N+cp_len) beats. With `tready` held high, `done` follows the last accepted beat by cfg_gap+1 cycles.
- **Downstream handshake:** `tdata`/`tlast` are stable while `tvalid`=1 and `tready`=0. `tvalid` never drops without a handshake, except on abort or reset.
- **Reset mid-frame:** all outputs return to reset values asynchronously. No pulses are emitted.

## Structure
- Package `ofdm_tx_pkg`: state enum `tx_seq_state_t`, constants NFFT_LOG2_MIN=6, NFFT_LOG2_MAX=12, and the config record typedef `tx_frame_cfg_t`.
- One sub-module, `axis_skid_fifo2`: the 2-entry FIFO with flush input, parameterised on data width (33 bits: tdata plus tlast).

## Test plan
- **Nominal frame:** nfft_log2=6, cp=16, syms=2, gap=0, tready=1, mem[a]=a. Expect 160 beats:
  - beats 0..15 = 48..63, beats 16..79 = 0..63;
  - beats 80..95 = 112..127, beats 96..159 = 64..127;
  - `tlast` only on beat 159; `done` one cycle later.
- **Backpressure:** same config with `tready` random at 50%. The recorded stream is identical to the nominal case. `tdata` is stable on every stalled cycle, and there is no duplicate or missing beat.
- **Config validation:**
  - cp=64, nfft_log2=6: `err_cfg` pulses, `busy` stays 0, `dac_fc_scaled` unchanged.
  - num_syms=0: `err_cfg` pulses.
  - cp=0: frame contains no prefix beats.
- **Config latch:** cfg_dac_fc=32'd107374182 and interp=40 applied at start. Changing cfg_* mid-frame leaves outputs and addresses unaffected.
- **Abort:** abort asserted at beat 70 of the nominal frame. Expect `tvalid`=0 on the next cycle, one `aborted` pulse, no `tlast`, no `done`. A following start produces a clean full frame.
- **Reset mid-frame:** `areset` asserted at beat 30. Expect immediate reset values. After release, a new start reproduces the nominal stream exactly. With gap=100, `done` arrives 101 cycles after the last beat.

Source files
------------

// File: rtl/ofdm_tx_frame_sequencer_pkg.sv
// Shared types and helpers for the OFDM TX frame sequencer.
package ofdm_tx_pkg;

    localparam int NFFT_LOG2_MIN = 6;
    localparam int NFFT_LOG2_MAX = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_BODY = 2'd2,
        ST_GAP  = 2'd3
    } tx_seq_state_t;

    // Shadow copy of the per-frame configuration; counts are widened to 16 bits.
    typedef struct packed {
        logic [3:0]  nfft_log2;
        logic [12:0] cp_len;
        logic [15:0] num_syms;
        logic [15:0] gap;
    } tx_frame_cfg_t;

    function automatic logic cfg_ok(input logic [3:0] l2, input logic [12:0] cp,
                                    input logic [15:0] ns);
        logic [13:0] n;
        n = 14'd1 << l2;
        return (l2 >= 4'(NFFT_LOG2_MIN)) && (l2 <= 4'(NFFT_LOG2_MAX)) &&
               ({1'b0, cp} < n) && (ns != 16'd0);
    endfunction

endpackage

// File: rtl/ofdm_tx_frame_sequencer_if.sv
// AXI-Stream style sample stream from the sequencer to the DUC.
interface ofdm_tx_frame_sequencer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [3:0]  tkeep;

    modport master (output tdata, tvalid, tlast, tkeep, input tready);
    modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/ofdm_tx_frame_sequencer_fifo.sv
// Two-entry output FIFO with synchronous flush; head entry is stable until popped.
module axis_skid_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = ~wr_q;
            end
            if (pop) rd_d = ~rd_q;
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/ofdm_tx_frame_sequencer.sv
// Reads one OFDM frame from sample memory, inserting a cyclic prefix per symbol,
// and streams it to the DUC; latches carrier word and interpolation at frame start.
module ofdm_tx_frame_sequencer
    import ofdm_tx_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          SYM_W      = 8,
    parameter int          GAP_W      = 16,
    parameter logic [31:0] FC_RST     = 32'd10737418,
    parameter logic [15:0] INTERP_RST = 16'd40
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_nfft_log2,
    input  logic [12:0]       cfg_cp_len,
    input  logic [SYM_W-1:0]  cfg_num_syms,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [31:0]       cfg_dac_fc,
    input  logic [15:0]       cfg_interp,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    ofdm_tx_frame_sequencer_if.master m_axis,
    output logic [31:0]       dac_fc_scaled,
    output logic [15:0]       interp_ratio,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err_cfg
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CP   = ST_CP;
    localparam logic [1:0] S_BODY = ST_BODY;
    localparam logic [1:0] S_GAP  = ST_GAP;

    logic [1:0]       state_q, state_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic [12:0]      idx_q, idx_d;
    tx_frame_cfg_t    cfg_q, cfg_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             inflight_q, inflight_d;
    logic             inflight_last_q, inflight_last_d;
    logic             last_issued_q, last_issued_d;
    logic             done_q, done_d, aborted_q, aborted_d, err_q, err_d;
    logic [31:0]      fc_q, fc_d;
    logic [15:0]      interp_q, interp_d;

    logic [32:0] fifo_dout;
    logic [1:0]  fifo_cnt;
    logic        tvalid, pop, flush, issue, body_end, last_sym;
    logic [2:0]  occ;
    logic [13:0] nfft, off;

    assign nfft     = 14'd1 << cfg_q.nfft_log2;
    assign tvalid   = fifo_cnt != 2'd0;
    assign pop      = tvalid && m_axis.tready;
    assign flush    = abort && (state_q != S_IDLE);
    // Count the beat leaving this cycle so a full-rate stream never bubbles.
    assign occ      = {1'b0, fifo_cnt} - {2'b0, pop} + {2'b0, inflight_q};
    assign issue    = ((state_q == S_CP) || (state_q == S_BODY && !last_issued_q)) &&
                      (occ < 3'd2) && !abort;
    assign body_end = idx_q == 13'(nfft - 14'd1);
    assign last_sym = 16'(sym_q) == (cfg_q.num_syms - 16'd1);
    assign off      = (state_q == S_CP) ? (nfft - {1'b0, cfg_q.cp_len} + {1'b0, idx_q})
                                        : {1'b0, idx_q};

    assign mem_ren   = issue;
    assign mem_raddr = (ADDR_W'(sym_q) << cfg_q.nfft_log2) + ADDR_W'(off);

    always_comb begin
        state_d         = state_q;
        sym_d           = sym_q;
        idx_d           = idx_q;
        cfg_d           = cfg_q;
        gap_d           = gap_q;
        last_issued_d   = last_issued_q;
        fc_d            = fc_q;
        interp_d        = interp_q;
        done_d          = 1'b0;
        aborted_d       = 1'b0;
        err_d           = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (state_q == S_BODY) && body_end && last_sym;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok(cfg_nfft_log2, cfg_cp_len, 16'(cfg_num_syms))) begin
                        cfg_d.nfft_log2 = cfg_nfft_log2;
                        cfg_d.cp_len    = cfg_cp_len;
                        cfg_d.num_syms  = 16'(cfg_num_syms);
                        cfg_d.gap       = 16'(cfg_gap);
                        fc_d            = cfg_dac_fc;
                        interp_d        = cfg_interp;
                        sym_d           = '0;
                        idx_d           = '0;
                        last_issued_d   = 1'b0;
                        state_d         = (cfg_cp_len == 13'd0) ? S_BODY : S_CP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CP: begin
                if (issue) begin
                    if (idx_q == cfg_q.cp_len - 13'd1) begin
                        idx_d   = '0;
                        state_d = S_BODY;
                    end else begin
                        idx_d = idx_q + 13'd1;
                    end
                end
            end
            S_BODY: begin
                if (issue) begin
                    if (body_end) begin
                        idx_d = '0;
                        if (last_sym) begin
                            last_issued_d = 1'b1;
                        end else begin
                            sym_d   = sym_q + SYM_W'(1);
                            state_d = (cfg_q.cp_len == 13'd0) ? S_BODY : S_CP;
                        end
                    end else begin
                        idx_d = idx_q + 13'd1;
                    end
                end
                // Frame completion is keyed on the tagged final beat leaving the FIFO.
                if (pop && fifo_dout[32]) begin
                    if (cfg_q.gap == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_W'(cfg_q.gap);
                        state_d = S_GAP;
                    end
                end
            end
            default: begin
                if (gap_q == GAP_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
        endcase

        if (flush) begin
            state_d         = S_IDLE;
            aborted_d       = 1'b1;
            done_d          = 1'b0;
            inflight_d      = 1'b0;
            inflight_last_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= S_IDLE;
            sym_q           <= '0;
            idx_q           <= '0;
            cfg_q           <= '0;
            gap_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            last_issued_q   <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            err_q           <= 1'b0;
            fc_q            <= FC_RST;
            interp_q        <= INTERP_RST;
        end else begin
            state_q         <= state_d;
            sym_q           <= sym_d;
            idx_q           <= idx_d;
            cfg_q           <= cfg_d;
            gap_q           <= gap_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            last_issued_q   <= last_issued_d;
            done_q          <= done_d;
            aborted_q       <= aborted_d;
            err_q           <= err_d;
            fc_q            <= fc_d;
            interp_q        <= interp_d;
        end
    end

    axis_skid_fifo2 #(.W(33)) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .flush (flush),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({inflight_last_q, mem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign m_axis.tdata  = fifo_dout[31:0];
    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tvalid && fifo_dout[32];
    assign m_axis.tkeep  = 4'b1111;

    assign dac_fc_scaled = fc_q;
    assign interp_ratio  = interp_q;
    assign busy          = state_q != S_IDLE;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign err_cfg       = err_q;
endmodule

// File: tb/tb_ofdm_tx_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_ofdm_tx_frame_sequencer;
    localparam logic [31:0] FC_RST     = 32'd10737418;
    localparam logic [15:0] INTERP_RST = 16'd40;
    localparam logic [31:0] FC_NEW     = 32'd107374182;

    logic        aclk = 1'b0, areset = 1'b1, start = 1'b0, abort = 1'b0, tready = 1'b1;
    logic [3:0]  cfg_nfft_log2 = 4'd6;
    logic [12:0] cfg_cp_len = 13'd16;
    logic [7:0]  cfg_num_syms = 8'd2;
    logic [15:0] cfg_gap = 16'd0;
    logic [31:0] cfg_dac_fc = FC_NEW;
    logic [15:0] cfg_interp = 16'd40;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] dac_fc_scaled;
    logic [15:0] interp_ratio;
    logic        busy, done, aborted, err_cfg;

    ofdm_tx_frame_sequencer_if axis_if ();
    assign axis_if.tready = tready;

    ofdm_tx_frame_sequencer dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .cfg_nfft_log2(cfg_nfft_log2), .cfg_cp_len(cfg_cp_len), .cfg_num_syms(cfg_num_syms),
        .cfg_gap(cfg_gap), .cfg_dac_fc(cfg_dac_fc), .cfg_interp(cfg_interp),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .m_axis(axis_if), .dac_fc_scaled(dac_fc_scaled), .interp_ratio(interp_ratio),
        .busy(busy), .done(done), .aborted(aborted), .err_cfg(err_cfg)
    );

    always #5 aclk = ~aclk;

    // Sample memory with mem[a] = a, one-cycle read latency.
    always @(posedge aclk) if (mem_ren) mem_rdata <= {16'h0, mem_raddr};

    int total = 0, bad = 0;
    int beats = 0, tlast_cnt = 0, done_cnt = 0, abort_cnt = 0, err_cnt = 0;
    int cyc = 0, last_cyc = 0, done_cyc = 0;
    bit rand_mode = 1'b0;
    logic [32:0] exp_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1 tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : monitor
        logic [32:0] e, prev_beat;
        bit stall_prev;
        stall_prev = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && !aborted) check("stall_valid", axis_if.tvalid, 1);
                if (stall_prev && axis_if.tvalid)
                    check("stall_hold", {axis_if.tlast, axis_if.tdata}, prev_beat);
                if (axis_if.tvalid && tready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got %0d want no beat", axis_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {axis_if.tlast, axis_if.tdata}, e);
                    end
                    if (axis_if.tlast) begin
                        tlast_cnt++;
                        last_cyc = cyc;
                    end
                end
                stall_prev = axis_if.tvalid && !tready;
                prev_beat  = {axis_if.tlast, axis_if.tdata};
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (aborted) abort_cnt++;
                if (err_cfg) err_cnt++;
            end
        end
    end

    task automatic set_cfg(input int l2, input int cp, input int ns, input int gp);
        cfg_nfft_log2 = 4'(l2);
        cfg_cp_len    = 13'(cp);
        cfg_num_syms  = 8'(ns);
        cfg_gap       = 16'(gp);
        cfg_dac_fc    = FC_NEW;
        cfg_interp    = 16'd40;
    endtask

    // Symbol s: prefix = tail of its body (s*N+N-cp ..), then body s*N .. s*N+N-1.
    task automatic push_frame(input int l2, input int cp, input int ns);
        int n;
        n = 1 << l2;
        for (int s = 0; s < ns; s++) begin
            for (int k = 0; k < cp; k++) exp_q.push_back({1'b0, 32'(s * n + n - cp + k)});
            for (int k = 0; k < n; k++)
                exp_q.push_back({1'((s == ns - 1) && (k == n - 1)), 32'(s * n + k)});
        end
    endtask

    task automatic pulse_start(input bit chk);
        @(posedge aclk);
        #1 start = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
        if (chk) begin
            @(negedge aclk);
            check("t1_busy", busy, 1);
            check("t1_mem_ren", mem_ren, 1);
            @(negedge aclk);
            check("t1_tvalid_low", axis_if.tvalid, 0);
            @(negedge aclk);
            check("t2_tvalid", axis_if.tvalid, 1);
        end
    endtask

    task automatic run_frame(input int l2, input int cp, input int ns, input int gp,
                             input bit rnd, input bit mess);
        int n, b0, t0, d0;
        bit got;
        set_cfg(l2, cp, ns, gp);
        n = 1 << l2;
        push_frame(l2, cp, ns);
        b0 = beats; t0 = tlast_cnt; d0 = done_cnt;
        rand_mode = rnd;
        pulse_start(1'b1);
        got = 1'b0;
        for (int k = 0; k < 20000 && !got; k++) begin
            @(posedge aclk);
            #2;
            if (mess && k == 20) begin
                cfg_cp_len = 13'd0; cfg_nfft_log2 = 4'd7; cfg_num_syms = 8'd5;
                cfg_gap = 16'd3; cfg_dac_fc = 32'd1; cfg_interp = 16'd7;
                start = 1'b1;
            end
            if (mess && k == 21) start = 1'b0;
            got = done_cnt != d0;
        end
        rand_mode = 1'b0;
        check("done_seen", got, 1);
        check("beat_count", beats - b0, ns * (n + cp));
        check("tlast_count", tlast_cnt - t0, 1);
        check("sb_empty", exp_q.size(), 0);
        check("done_delay", done_cyc - last_cyc, gp + 1);
        @(negedge aclk);
        check("idle_busy", busy, 0);
        check("fc_latched", dac_fc_scaled, FC_NEW);
        check("interp_latched", interp_ratio, 40);
        exp_q.delete();
    endtask

    task automatic try_bad(input int l2, input int cp, input int ns);
        int e0;
        set_cfg(l2, cp, ns, 0);
        cfg_dac_fc = 32'd5;
        e0 = err_cnt;
        pulse_start(1'b0);
        @(negedge aclk);
        check("err_pulse", err_cfg, 1);
        check("err_busy", busy, 0);
        @(negedge aclk);
        check("err_pulse_end", err_cfg, 0);
        check("err_fc_kept", dac_fc_scaled, FC_NEW);
        check("err_count", err_cnt - e0, 1);
    endtask

    task automatic wait_beats(input int nb, input int b0);
        for (int k = 0; k < 2000 && (beats - b0) < nb; k++) begin
            @(posedge aclk);
            #2;
        end
    endtask

    initial begin : stim
        int b0, t0, d0, a0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", axis_if.tvalid, 0);
        check("rst_tlast", axis_if.tlast, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, aborted, err_cfg}, 0);
        check("rst_fc", dac_fc_scaled, FC_RST);
        check("rst_interp", interp_ratio, INTERP_RST);
        check("tkeep", axis_if.tkeep, 4'hF);
        areset = 1'b0;

        run_frame(6, 16, 2, 0, 1'b0, 1'b0);
        run_frame(6, 16, 2, 0, 1'b1, 1'b1);
        try_bad(6, 64, 2);
        try_bad(6, 16, 0);
        try_bad(13, 0, 1);
        run_frame(6, 0, 1, 0, 1'b0, 1'b0);

        // abort and start together in IDLE
        set_cfg(6, 16, 2, 0);
        @(posedge aclk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge aclk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge aclk);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_pulses", {aborted, err_cfg, mem_ren}, 0);

        // abort at beat 70
        set_cfg(6, 16, 2, 0);
        push_frame(6, 16, 2);
        b0 = beats; t0 = tlast_cnt; d0 = done_cnt; a0 = abort_cnt;
        pulse_start(1'b0);
        wait_beats(70, b0);
        abort = 1'b1;
        @(posedge aclk);
        #1 abort = 1'b0;
        @(negedge aclk);
        check("abort_tvalid", axis_if.tvalid, 0);
        check("abort_pulse", aborted, 1);
        check("abort_busy", busy, 0);
        exp_q.delete();
        repeat (30) @(negedge aclk);
        check("abort_once", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_tlast", tlast_cnt - t0, 0);
        run_frame(6, 16, 2, 0, 1'b0, 1'b0);

        // reset at beat 30
        set_cfg(6, 16, 2, 0);
        push_frame(6, 16, 2);
        b0 = beats;
        pulse_start(1'b0);
        wait_beats(30, b0);
        #1 areset = 1'b1;
        #1;
        check("mrst_tvalid", axis_if.tvalid, 0);
        check("mrst_tlast", axis_if.tlast, 0);
        check("mrst_busy", busy, 0);
        check("mrst_mem_ren", mem_ren, 0);
        check("mrst_pulses", {done, aborted, err_cfg}, 0);
        check("mrst_fc", dac_fc_scaled, FC_RST);
        check("mrst_interp", interp_ratio, INTERP_RST);
        exp_q.delete();
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        run_frame(6, 16, 2, 100, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
